// File: rtl/uart_receiver.sv
// uart_receiver: 16x oversampled 8E1 UART receiver with 2-of-3 mid-bit majority sampling
module uart_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int OVERSAMPLE  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    input  logic [2:0] baud_select,
    input  logic       Rx_EN,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);
    localparam int TW = $clog2(OVERSAMPLE);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] sync;
    logic rxs, sample_tick, t9, t15, maj, s7, s8, par, armed;
    logic [2:0] baud_q, idx;
    logic [14:0] div_cnt, divisor;
    logic [TW-1:0] tick_cnt;
    logic [7:0] shadow;

    assign rxs = sync[SYNC_STAGES-1];
    always_comb begin
        divisor = baud_q == 3'd0 ? 15'd20833 :
                  baud_q == 3'd1 ? 15'd5208  :
                  baud_q == 3'd2 ? 15'd1302  :
                  baud_q == 3'd3 ? 15'd651   :
                  baud_q == 3'd4 ? 15'd326   :
                  baud_q == 3'd5 ? 15'd163   :
                  baud_q == 3'd6 ? 15'd109   : 15'd54;
        sample_tick = div_cnt == divisor - 15'd1;
        t9  = sample_tick && tick_cnt == TW'(9);
        t15 = sample_tick && tick_cnt == TW'(OVERSAMPLE - 1);
        maj = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) sync <= '1;
        else sync <= {sync[SYNC_STAGES-2:0], RxD};

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            tick_cnt  <= '0;
            idx       <= '0;
            baud_q    <= '0;
            shadow    <= '0;
            s7        <= 1'b0;
            s8        <= 1'b0;
            par       <= 1'b0;
            armed     <= 1'b1;
            Rx_DATA   <= '0;
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
        end else begin
            Rx_VALID <= 1'b0;
            div_cnt  <= sample_tick ? '0 : div_cnt + 15'd1;
            if (sample_tick) tick_cnt <= tick_cnt + TW'(1);
            if (sample_tick && tick_cnt == TW'(7)) s7 <= rxs;
            if (sample_tick && tick_cnt == TW'(8)) s8 <= rxs;
            if (!Rx_EN) state <= IDLE;
            else case (state)
                IDLE: begin
                    if (rxs) armed <= 1'b1;
                    if (armed && !rxs) begin
                        div_cnt   <= '0;
                        tick_cnt  <= '0;
                        baud_q    <= baud_select;
                        Rx_PERROR <= 1'b0;
                        Rx_FERROR <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (t9 && maj) state <= IDLE;
                    else if (t15) begin
                        idx   <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (t9) shadow[idx] <= maj;
                    if (t15) begin
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) state <= PARITY;
                    end
                end
                PARITY: begin
                    if (t9) par <= maj;
                    if (t15) state <= STOP;
                end
                STOP: begin
                    // decide at mid-stop so a back-to-back start bit is never missed
                    if (t9) begin
                        Rx_DATA   <= shadow;
                        Rx_PERROR <= ^shadow ^ par;
                        Rx_FERROR <= ~maj;
                        Rx_VALID  <= ~(^shadow ^ par) & maj;
                        armed     <= maj;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: table-driven and randomized frame checks against a frame-level reference model
module tb_uart_receiver;
    localparam int BIT = 864;
    localparam int TICK = 54;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        logic       chg;
        logic [7:0] exp_d;
        logic       exp_v;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    logic clk = 1'b0, reset = 1'b1, RxD = 1'b1, Rx_EN = 1'b1;
    logic [2:0] baud_select = 3'b111;
    logic [7:0] Rx_DATA;
    logic Rx_VALID, Rx_PERROR, Rx_FERROR;
    int checks = 0, fails = 0;
    int cyc = 0, multi = 0, ferr_rises = 0;
    int vq[$];
    logic [7:0] dq[$];
    logic prev_v = 1'b0, prev_f = 1'b0;

    uart_receiver dut (
        .clk(clk),
        .reset(reset),
        .RxD(RxD),
        .baud_select(baud_select),
        .Rx_EN(Rx_EN),
        .Rx_DATA(Rx_DATA),
        .Rx_VALID(Rx_VALID),
        .Rx_PERROR(Rx_PERROR),
        .Rx_FERROR(Rx_FERROR)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (Rx_VALID) begin
            vq.push_back(cyc);
            dq.push_back(Rx_DATA);
        end
        if (Rx_VALID && prev_v) multi <= multi + 1;
        if (Rx_FERROR && !prev_f) ferr_rises <= ferr_rises + 1;
        prev_v <= Rx_VALID;
        prev_f <= Rx_FERROR;
    end

    // expected {valid, perror, ferror} from the bits actually put on the line
    function automatic logic [2:0] model(input logic [7:0] d, input logic p, input logic s);
        logic pe, fe;
        pe = ($countones({d, p}) % 2) == 1;
        fe = !s;
        return {!pe && !fe, pe, fe};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input logic chg,
                              input logic [7:0] ed, input logic ev, input logic epe, input logic efe,
                              output int vt);
        logic [10:0] bits;
        int st;
        bits = {s, p, d, 1'b0};
        st = cyc;
        for (int i = 0; i < 11; i++) begin
            RxD = bits[i];
            if (chg && i == 5) baud_select = 3'b000;
            if (chg && i == 10) baud_select = 3'b111;
            idle(BIT);
            if (i == 0) check("flags cleared at start", 32'({Rx_PERROR, Rx_FERROR}), 32'd0);
        end
        check("valid count", 32'(vq.size()), 32'(ev));
        vt = -1;
        if (vq.size() == 1) begin
            vt = vq[0];
            check("valid in stop bit", 32'(vq[0] - st >= BIT * 21 / 2 && vq[0] - st < BIT * 11), 32'd1);
            check("valid data", 32'(dq[0]), 32'(ed));
        end
        vq.delete();
        dq.delete();
        check("rx_data", 32'(Rx_DATA), 32'(ed));
        check("perror", 32'(Rx_PERROR), 32'(epe));
        check("ferror", 32'(Rx_FERROR), 32'(efe));
    endtask

    initial begin
        vec_t tbl[3];
        logic [7:0] d;
        logic [2:0] m;
        int vt, prev_vt, f0, g;
        tbl[0] = '{8'h6C, 1'b0, 1'b1, 1'b0, 8'h6C, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'hEA, 1'b1, 1'b1, 1'b1, 8'hEA, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'hEA, 1'b0, 1'b1, 1'b0, 8'hEA, 1'b0, 1'b1, 1'b0};

        idle(5);
        check("reset rx_data", 32'(Rx_DATA), 32'h00);
        check("reset valid", 32'(Rx_VALID), 32'd0);
        check("reset perror", 32'(Rx_PERROR), 32'd0);
        check("reset ferror", 32'(Rx_FERROR), 32'd0);
        reset = 1'b0;
        idle(BIT);
        check("no valid at idle", 32'(vq.size()), 32'd0);

        prev_vt = -1;
        for (int k = 0; k < 3; k++) begin
            send_frame(tbl[k].d, tbl[k].p, tbl[k].s, tbl[k].chg,
                       tbl[k].exp_d, tbl[k].exp_v, tbl[k].exp_pe, tbl[k].exp_fe, vt);
            if (k > 0 && tbl[k].exp_v && tbl[k-1].exp_v)
                check("back-to-back spacing", 32'(vt - prev_vt), 32'(11 * BIT));
            prev_vt = vt;
        end

        d = 8'($urandom);
        m = model(d, ^d, 1'b0);
        f0 = ferr_rises;
        send_frame(d, ^d, 1'b0, 1'b0, d, m[2], m[1], m[0], vt);
        idle(16 * BIT);
        check("single ferror on stuck line", 32'(ferr_rises - f0), 32'd1);
        check("no frame on stuck line", 32'(vq.size()), 32'd0);
        check("ferror held", 32'(Rx_FERROR), 32'd1);
        RxD = 1'b1;
        idle(2 * BIT);
        m = model(8'h55, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b1, 1'b0, 8'h55, m[2], m[1], m[0], vt);

        g = $urandom_range(2, 4);
        RxD = 1'b0;
        idle(g * TICK);
        RxD = 1'b1;
        idle(2 * BIT);
        check("glitch valid", 32'(vq.size()), 32'd0);
        check("glitch flags", 32'({Rx_PERROR, Rx_FERROR}), 32'd0);
        check("glitch rx_data", 32'(Rx_DATA), 32'h55);

        d = 8'hF0;
        RxD = 1'b0;
        idle(BIT);
        for (int i = 0; i < 4; i++) begin
            RxD = d[i];
            idle(BIT);
        end
        RxD = 1'b1;
        Rx_EN = 1'b0;
        idle(10);
        Rx_EN = 1'b1;
        idle(8 * BIT);
        check("enable abort valid", 32'(vq.size()), 32'd0);
        check("enable abort rx_data", 32'(Rx_DATA), 32'h55);
        check("enable abort flags", 32'({Rx_PERROR, Rx_FERROR}), 32'd0);

        d = 8'($urandom);
        RxD = 1'b0;
        idle(BIT);
        for (int i = 0; i < 5; i++) begin
            RxD = d[i];
            idle(i == 4 ? BIT / 2 : BIT);
        end
        #2 reset = 1'b1;
        #1;
        check("async reset rx_data", 32'(Rx_DATA), 32'h00);
        check("async reset flags", 32'({Rx_VALID, Rx_PERROR, Rx_FERROR}), 32'd0);
        RxD = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(2 * BIT);
        check("reset abort valid", 32'(vq.size()), 32'd0);
        m = model(8'hA5, 1'b0, 1'b1);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, m[2], m[1], m[0], vt);

        check("valid one cycle wide", 32'(multi), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
